// File: rtl/i_line_prefetcher.sv
// i_line_prefetcher: fetches the missing I-line, then sequential lines, as AXI read bursts into a line FIFO.
// Optional macro I_PREFETCH_RID_CHECK_EN: accept only R beats whose RID equals AXI_ID.
module i_line_prefetcher #(
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned BLOCK_OFFSET_WIDTH = 2,
    parameter int unsigned DEPTH              = 4,
    parameter logic [3:0]  AXI_ID             = 4'd2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         req_valid_i,
    input  logic [ADDR_WIDTH-1:0]                        req_addr_i,
    output logic                                         req_ready_o,
    input  logic                                         flush_i,
    output logic                                         line_valid_o,
    output logic [ADDR_WIDTH-1:0]                        line_addr_o,
    output logic [(1<<BLOCK_OFFSET_WIDTH)*DATA_WIDTH-1:0] line_data_o,
    input  logic                                         line_pop_i,
    output logic [ADDR_WIDTH-1:0]                        ar_addr_o,
    output logic [7:0]                                   ar_len_o,
    output logic [3:0]                                   ar_id_o,
    output logic                                         ar_valid_o,
    input  logic                                         ar_ready_i,
    input  logic [DATA_WIDTH-1:0]                        r_data_i,
    input  logic [3:0]                                   r_id_i,
    input  logic                                         r_last_i,
    input  logic                                         r_valid_i,
    output logic                                         r_ready_o
);
    localparam int unsigned LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH;
    localparam int unsigned LINE_W    = LINE_SIZE * DATA_WIDTH;
    localparam int unsigned OFF_W     = BLOCK_OFFSET_WIDTH + 2;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0]         LINE_INC  = ADDR_WIDTH'(LINE_SIZE * 4);
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_BEAT = BLOCK_OFFSET_WIDTH'(LINE_SIZE - 1);
    localparam logic [CNT_W-1:0]              FULL      = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]              PTR_LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT} state_e;

    state_e                        state_q, state_d;
    logic                          drop_q;
    logic [BLOCK_OFFSET_WIDTH-1:0] beat_q;
    logic [ADDR_WIDTH-1:0]         next_line_q;
    logic [LINE_W-1:0]             asm_q, asm_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [PTR_W-1:0]              wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH-1:0]         addr_mem_q [DEPTH];
    logic [LINE_W-1:0]             data_mem_q [DEPTH];

    logic rid_ok, beat_fire, burst_end, drop_eff, req_fire, fifo_clr, push, pop;

`ifdef I_PREFETCH_RID_CHECK_EN
    assign rid_ok = (r_id_i == AXI_ID);
`else
    logic unused_rid;
    assign unused_rid = ^r_id_i;
    assign rid_ok     = 1'b1;
`endif

    // A flush arriving in the same cycle as the final beat must already suppress that push.
    always_comb begin
        beat_fire = (state_q == S_DATA) && r_valid_i && rid_ok;
        burst_end = beat_fire && (r_last_i || (beat_q == LAST_BEAT));
        drop_eff  = drop_q || flush_i;
        req_fire  = req_valid_i && req_ready_o;
        fifo_clr  = flush_i || req_fire;
        push      = burst_end && !drop_eff;
        pop       = line_pop_i && (count_q != '0) && !fifo_clr;
        asm_d     = asm_q;
        asm_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = r_data_i;
        if (fifo_clr) count_d = '0;
        else          count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!flush_i && req_fire) state_d = S_ADDR;
            S_WAIT: begin
                if (flush_i)                state_d = S_IDLE;
                else if (req_fire)          state_d = S_ADDR;
                else if (count_d < FULL)    state_d = S_ADDR;
            end
            S_ADDR: if (ar_ready_i) state_d = S_DATA;
            S_DATA: begin
                if (burst_end) begin
                    if (drop_eff)             state_d = S_IDLE;
                    else if (count_d < FULL)  state_d = S_ADDR;
                    else                      state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = ((state_q == S_IDLE) || (state_q == S_WAIT)) && !flush_i;
        ar_valid_o   = (state_q == S_ADDR);
        ar_addr_o    = next_line_q;
        ar_len_o     = (state_q == S_ADDR) ? 8'(LINE_SIZE - 1) : '0;
        ar_id_o      = AXI_ID;
        r_ready_o    = (state_q == S_DATA);
        line_valid_o = (count_q != '0);
        line_addr_o  = line_valid_o ? addr_mem_q[rd_ptr_q] : '0;
        line_data_o  = line_valid_o ? data_mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q      <= 1'b0;
            beat_q      <= '0;
            next_line_q <= '0;
            asm_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            count_q <= count_d;
            if ((state_q == S_DATA) && burst_end)
                drop_q <= 1'b0;
            else if (flush_i && ((state_q == S_ADDR) || (state_q == S_DATA)))
                drop_q <= 1'b1;

            if ((state_q == S_ADDR) && ar_ready_i) beat_q <= '0;
            else if (beat_fire)                    beat_q <= burst_end ? '0 : beat_q + 1'b1;

            if (beat_fire) asm_q <= burst_end ? '0 : asm_d;

            if (req_fire)       next_line_q <= {req_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            else if (burst_end) next_line_q <= next_line_q + LINE_INC;

            if (fifo_clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= next_line_q;
            data_mem_q[wr_ptr_q] <= asm_d;
        end
    end
endmodule

// File: doc/i_line_prefetcher.md
# i_line_prefetcher

Sequential instruction-line prefetch engine between the instruction stream buffer and the AXI read channel. On an I-cache miss request it fetches the missing line, then the following sequential lines, as AXI read bursts. Completed lines go into a small line FIFO, which the stream buffer reads and pops. The stream buffer no longer drives memory directly.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, AXI beat / instruction word width
- BLOCK_OFFSET_WIDTH, 2, log2 words per line; LINE_SIZE = 1<<BLOCK_OFFSET_WIDTH, LINE_BYTES = LINE_SIZE*4
- DEPTH, 4, line FIFO entries (≥2)
- AXI_ID, 4'd2, ARID driven and RID matched
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  miss request
- req_addr  in  ADDR_WIDTH  missing PC (byte address)
- req_ready  out  1  request accepted when high with req_valid
- flush  in  1  discard all buffered/in-flight lines
- line_valid  out  1  FIFO head valid
- line_addr  out  ADDR_WIDTH  line-aligned address of head
- line_data  out  LINE_SIZE*DATA_WIDTH  head words, word 0 in LSBs
- line_pop  in  1  consumer removes head
- ar_addr  out  ADDR_WIDTH  burst address
- ar_len  out  8  burst length minus one
- ar_id  out  4  AXI_ID
- ar_valid  out  1  address valid
- ar_ready  in  1  address accepted
- r_data  in  DATA_WIDTH  beat data
- r_id  in  4  beat ID
- r_last  in  1  final beat
- r_valid  in  1  beat valid
- r_ready  out  1  beat accept

## Operation
- FSM states: IDLE, ADDR, DATA, WAIT.
- req_ready = (state is IDLE or WAIT) and !flush.
- Request accepted:
  - Clear the FIFO.
  - next_line = req_addr with its low BLOCK_OFFSET_WIDTH+2 bits zeroed.
  - Go to ADDR.
- ADDR:
  - Drive ar_valid=1, ar_addr=next_line, ar_len=LINE_SIZE-1, ar_id=AXI_ID.
  - Hold all fields stable until ar_ready.
  - On ar_valid&&ar_ready: go to DATA with beat=0.
- DATA:
  - Drive r_ready=1.
  - Each accepted beat writes assembly word[beat] and increments beat.
  - The burst ends on the beat with r_last=1, or when beat==LINE_SIZE-1, whichever comes first.
  - End of burst:
    - Push {next_line, assembly} into the FIFO unless drop is set.
    - next_line += LINE_BYTES, wrapping modulo 2^ADDR_WIDTH.
    - Then: drop set → IDLE and clear drop; FIFO count after push < DEPTH → ADDR; otherwise → WAIT.
- WAIT: go to ADDR when count < DEPTH.
- line_valid = count != 0. line_pop with an empty FIFO is ignored. A push and a pop in the same cycle leave count unchanged.
- flush:
  - In IDLE or WAIT: clear the FIFO and go to IDLE.
  - In ADDR or DATA: clear the FIFO and set drop. The AXI transaction is never abandoned: the address handshake and all beats complete, the line is discarded, then the FSM goes to IDLE.
  - flush has priority over req_valid in the same cycle.
- Pops arriving during drop are ignored (FIFO already empty).

## Timing
- Reset values:
  - state=IDLE, count=0, drop=0, beat=0, next_line=0.
  - ar_valid=0, ar_addr=0, ar_len=0, ar_id=AXI_ID, r_ready=0.
  - line_valid=0, line_addr=0, line_data=0, req_ready=1.
- Reset mid-burst returns to IDLE immediately. Outstanding beats arriving afterwards are ignored because r_ready=0.
- All AXI and line outputs are registered or decoded from registered state. There is no combinational path from r_* to ar_*.
- Request accepted in cycle t → ar_valid=1 in t+1.
- Final beat accepted in cycle t → line_valid=1 and line_addr/line_data updated in t+1 (if the FIFO was empty); ar_valid for the next line in t+1.
- A pop in cycle t from WAIT → ar_valid in t+1.
- Minimum request-to-line latency: 1 + 1 (ar) + LINE_SIZE beats + 1.

## Configuration
- I_PREFETCH_RID_CHECK_EN defined:
  - A beat is accepted only if r_valid && r_id==AXI_ID.
  - A non-matching beat is ignored: beat, assembly and burst-end logic are unaffected. r_ready stays 1 for it.
- Not defined: r_id is unused and every r_valid beat in DATA is accepted.

## Test plan
- Baseline fetch: rst, then req_addr=0x0000_0104 → ar_valid next cycle with ar_addr=0x100, ar_len=3. Four beats 0xA0..0xA3 with r_last on the 4th → line_valid=1, line_addr=0x100, line_data=0xA3_A2_A1_A0 (per-word), then ar_addr=0x110.
- Fill/backpressure: DEPTH=4, no pops → bursts 0x100, 0x110, 0x120, 0x130, then WAIT with ar_valid=0. One line_pop → ar_valid=1 with ar_addr=0x140 next cycle.
- Flush mid-burst: flush during beat 2 of 0x110 → remaining beats accepted, no push, line_valid=0, state IDLE, no further ar_valid. A new req of 0x200 → ar_addr=0x200.
- Wrap: req_addr=0xFFFF_FFF8 → ar_addr=0xFFFF_FFF0, next burst ar_addr=0x0000_0000.
- Simultaneous push/pop: count=3, final beat and line_pop in the same cycle → count stays 3, FSM goes to ADDR (not WAIT), head advances.
- RID filter (macro on): beat with r_id=4'd5 in the middle of a burst → ignored, line data contains only the AXI_ID beats. Macro off → the same beat is captured as word[n].
